positron_layer_serializer: RTL and testbench

//  Collects the single end-of-window output posit of each of NB_POSITRON parallel positrons in one layer.
//  Re-emits the collected posits as one serial window for the next layer: lane 0 first, sow on the first beat, eow on the last.

---
 rtl/positron_layer_serializer_if.sv | 26 ++
 rtl/positron_layer_serializer.sv | 69 ++++++
 tb/tb_positron_layer_serializer.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/positron_layer_serializer_if.sv
// Handshake bundle between one positron layer and the serializer feeding the next layer.
// The slave modport is the serializer's view; master is the environment driving it.
interface positron_layer_serializer_if #(
  parameter int unsigned POSIT_WIDTH = 4,
  parameter int unsigned NB_POSITRON = 16
);
  logic [NB_POSITRON-1:0]             rts_i;
  logic [NB_POSITRON-1:0]             eow_i;
  logic [NB_POSITRON*POSIT_WIDTH-1:0] posit_i;
  logic [NB_POSITRON-1:0]             rtr_o;
  logic                               rtr_i;
  logic                               rts_o;
  logic                               sow_o;
  logic                               eow_o;
  logic [POSIT_WIDTH-1:0]             posit_o;

  modport slave (
    input  rts_i, eow_i, posit_i, rtr_i,
    output rtr_o, rts_o, sow_o, eow_o, posit_o
  );

  modport master (
    output rts_i, eow_i, posit_i, rtr_i,
    input  rtr_o, rts_o, sow_o, eow_o, posit_o
  );
endinterface

// File: rtl/positron_layer_serializer.sv
// Gathers one end-of-window posit per upstream lane, then replays them lane 0 first
// as a single serial window (sow on first beat, eow on last) for the next layer.
module positron_layer_serializer #(
  parameter int unsigned POSIT_WIDTH = 4,
  parameter int unsigned NB_POSITRON = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  positron_layer_serializer_if.slave    bus
);

  localparam int unsigned IDX_W = (NB_POSITRON > 1) ? $clog2(NB_POSITRON) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NB_POSITRON - 1);

  typedef enum logic {COLLECT, EMIT} state_t;

  state_t                                  state;
  logic [NB_POSITRON-1:0]                  captured;
  logic [IDX_W-1:0]                        idx;
  logic [NB_POSITRON-1:0][POSIT_WIDTH-1:0] buffer;
  logic [NB_POSITRON-1:0]                  rtr;
  logic [NB_POSITRON-1:0]                  accept;

  // A lane that already delivered stays back-pressured until its posit is emitted.
  always_comb begin
    rtr    = (state == COLLECT) ? ~captured : '0;
    accept = bus.rts_i & bus.eow_i & rtr;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= COLLECT;
      captured <= '0;
      idx      <= '0;
      buffer   <= '0;
    end else begin
      case (state)
        COLLECT: begin
          for (int unsigned k = 0; k < NB_POSITRON; k++) begin
            if (accept[k]) buffer[k] <= bus.posit_i[k*POSIT_WIDTH +: POSIT_WIDTH];
          end
          captured <= captured | accept;
          if ((captured | accept) == '1) state <= EMIT;
        end
        EMIT: begin
          if (bus.rtr_i) begin
            if (idx == LAST_IDX) begin
              idx      <= '0;
              captured <= '0;
              state    <= COLLECT;
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

  always_comb begin
    bus.rtr_o   = rtr;
    bus.rts_o   = (state == EMIT);
    bus.sow_o   = (state == EMIT) && (idx == '0);
    bus.eow_o   = (state == EMIT) && (idx == LAST_IDX);
    bus.posit_o = (state == EMIT) ? buffer[idx] : '0;
  end

endmodule

// File: tb/tb_positron_layer_serializer.sv
// Bench for positron_layer_serializer: directed vector table, hand-written reset and
// single-lane sequences, and random traffic against a queue-based reference model.
module tb_positron_layer_serializer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  positron_layer_serializer_if #(.POSIT_WIDTH(4), .NB_POSITRON(4)) bus4 ();
  positron_layer_serializer_if #(.POSIT_WIDTH(4), .NB_POSITRON(1)) bus1 ();

  positron_layer_serializer #(.POSIT_WIDTH(4), .NB_POSITRON(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(bus4)
  );
  positron_layer_serializer #(.POSIT_WIDTH(4), .NB_POSITRON(1)) u_one (
    .clk(clk), .rst_n(rst_n), .bus(bus1)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Expected-output packing: {rts, sow, eow, posit[3:0], rtr[3:0]}
  typedef struct packed {
    logic [3:0]  rts;
    logic [3:0]  eow;
    logic [15:0] posit;
    logic        rtr_i;
    logic [10:0] exp;
  } vec_t;

  function automatic vec_t mk(logic e_rts, logic e_sow, logic e_eow, logic [3:0] e_posit,
                              logic [3:0] e_rtr, logic [3:0] rts, logic [3:0] eow,
                              logic [15:0] posit, logic rtr_i);
    vec_t v;
    v.rts   = rts;
    v.eow   = eow;
    v.posit = posit;
    v.rtr_i = rtr_i;
    v.exp   = {e_rts, e_sow, e_eow, e_posit, e_rtr};
    return v;
  endfunction

  function automatic logic [10:0] obs4();
    return {bus4.rts_o, bus4.sow_o, bus4.eow_o, bus4.posit_o, bus4.rtr_o};
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive4(logic [3:0] rts, logic [3:0] eow, logic [15:0] posit, logic rtr_i);
    bus4.rts_i   = rts;
    bus4.eow_i   = eow;
    bus4.posit_i = posit;
    bus4.rtr_i   = rtr_i;
  endtask

  // Reference model: a window fills lane by lane, then is replayed from a FIFO.
  logic [3:0] m_got;
  logic [3:0] m_buf [4];
  logic [3:0] m_q [$];

  function automatic logic [10:0] model_exp();
    if (m_q.size() > 0)
      return {1'b1, m_q.size() == 4, m_q.size() == 1, m_q[0], 4'b0000};
    return {3'b000, 4'h0, ~m_got};
  endfunction

  task automatic model_step(logic [3:0] rts, logic [3:0] eow, logic [15:0] posit, logic rtr_i);
    if (m_q.size() > 0) begin
      if (rtr_i) void'(m_q.pop_front());
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (rts[k] && eow[k] && !m_got[k]) begin
          m_buf[k] = posit[k*4 +: 4];
          m_got[k] = 1'b1;
        end
      end
      if (m_got == 4'hF) begin
        for (int k = 0; k < 4; k++) m_q.push_back(m_buf[k]);
        m_got = 4'h0;
      end
    end
  endtask

  vec_t vecs [24];

  initial begin
    logic [3:0]  r_rts, r_eow;
    logic [15:0] r_posit;
    logic        r_rtr;

    drive4(4'h0, 4'h0, 16'h0, 1'b0);
    bus1.rts_i = 1'b0; bus1.eow_i = 1'b0; bus1.posit_i = 4'h0; bus1.rtr_i = 1'b0;
    m_got = 4'h0;

    // Test 1: lanes one per cycle; test 2: all at once; test 3: rtr_i stalls;
    // tests 4/5: double assert on lane 2, rts without eow on lane 1.
    vecs[0]  = mk(0,0,0,4'h0,4'hF, 4'b0001,4'b0001,16'h4321,1);
    vecs[1]  = mk(0,0,0,4'h0,4'hE, 4'b0010,4'b0010,16'h4321,1);
    vecs[2]  = mk(0,0,0,4'h0,4'hC, 4'b0100,4'b0100,16'h4321,1);
    vecs[3]  = mk(0,0,0,4'h0,4'h8, 4'b1000,4'b1000,16'h4321,1);
    vecs[4]  = mk(1,1,0,4'h1,4'h0, 4'b0000,4'b0000,16'h0000,1);
    vecs[5]  = mk(1,0,0,4'h2,4'h0, 4'b0000,4'b0000,16'h0000,1);
    vecs[6]  = mk(1,0,0,4'h3,4'h0, 4'b0000,4'b0000,16'h0000,1);
    vecs[7]  = mk(1,0,1,4'h4,4'h0, 4'b0000,4'b0000,16'h0000,1);
    vecs[8]  = mk(0,0,0,4'h0,4'hF, 4'b1111,4'b1111,16'hF807,1);
    vecs[9]  = mk(1,1,0,4'h7,4'h0, 4'b0000,4'b0000,16'h0000,1);
    vecs[10] = mk(1,0,0,4'h0,4'h0, 4'b0000,4'b0000,16'h0000,0);
    vecs[11] = mk(1,0,0,4'h0,4'h0, 4'b0000,4'b0000,16'h0000,0);
    vecs[12] = mk(1,0,0,4'h0,4'h0, 4'b0000,4'b0000,16'h0000,1);
    vecs[13] = mk(1,0,0,4'h8,4'h0, 4'b0000,4'b0000,16'h0000,1);
    vecs[14] = mk(1,0,1,4'hF,4'h0, 4'b0000,4'b0000,16'h0000,1);
    vecs[15] = mk(0,0,0,4'h0,4'hF, 4'b0100,4'b0100,16'h0A00,1);
    vecs[16] = mk(0,0,0,4'h0,4'hB, 4'b0100,4'b0100,16'h0500,1);
    vecs[17] = mk(0,0,0,4'h0,4'hB, 4'b0010,4'b0000,16'h0090,1);
    vecs[18] = mk(0,0,0,4'h0,4'hB, 4'b1011,4'b1011,16'hE6DC,1);
    vecs[19] = mk(1,1,0,4'hC,4'h0, 4'b0000,4'b0000,16'h0000,1);
    vecs[20] = mk(1,0,0,4'hD,4'h0, 4'b0000,4'b0000,16'h0000,1);
    vecs[21] = mk(1,0,0,4'hA,4'h0, 4'b0000,4'b0000,16'h0000,1);
    vecs[22] = mk(1,0,1,4'hE,4'h0, 4'b0000,4'b0000,16'h0000,1);
    vecs[23] = mk(0,0,0,4'h0,4'hF, 4'b0000,4'b0000,16'h0000,1);

    repeat (2) @(negedge clk);
    check("reset_nb4", 32'(obs4()), 32'({3'b000, 4'h0, 4'hF}));
    check("reset_nb1", 32'({bus1.rts_o, bus1.sow_o, bus1.eow_o, bus1.posit_o, bus1.rtr_o}),
          32'({3'b000, 4'h0, 1'b1}));
    rst_n = 1'b1;

    for (int i = 0; i < 24; i++) begin
      check($sformatf("vec%0d", i), 32'(obs4()), 32'(vecs[i].exp));
      drive4(vecs[i].rts, vecs[i].eow, vecs[i].posit, vecs[i].rtr_i);
      @(negedge clk);
    end

    // Reset during the second beat discards the window.
    drive4(4'hF, 4'hF, 16'h4321, 1'b1);
    @(negedge clk);
    check("rst_beat1", 32'(obs4()), 32'({3'b110, 4'h1, 4'h0}));
    drive4(4'h0, 4'h0, 16'h0, 1'b1);
    @(negedge clk);
    check("rst_beat2", 32'(obs4()), 32'({3'b100, 4'h2, 4'h0}));
    rst_n = 1'b0;
    #1;
    check("rst_async", 32'(obs4()), 32'({3'b000, 4'h0, 4'hF}));
    @(negedge clk);
    rst_n = 1'b1;
    check("rst_release", 32'(obs4()), 32'({3'b000, 4'h0, 4'hF}));
    drive4(4'b0111, 4'b0111, 16'h0CBA, 1'b1);
    @(negedge clk);
    drive4(4'h0, 4'h0, 16'h0, 1'b1);
    repeat (3) @(negedge clk);
    check("rst_partial", 32'(obs4()), 32'({3'b000, 4'h0, 4'h8}));
    drive4(4'b1000, 4'b1000, 16'hD000, 1'b1);
    @(negedge clk);
    drive4(4'h0, 4'h0, 16'h0, 1'b1);
    check("rst_new_b1", 32'(obs4()), 32'({3'b110, 4'hA, 4'h0}));
    @(negedge clk);
    check("rst_new_b2", 32'(obs4()), 32'({3'b100, 4'hB, 4'h0}));
    @(negedge clk);
    check("rst_new_b3", 32'(obs4()), 32'({3'b100, 4'hC, 4'h0}));
    @(negedge clk);
    check("rst_new_b4", 32'(obs4()), 32'({3'b101, 4'hD, 4'h0}));
    @(negedge clk);
    check("rst_new_idle", 32'(obs4()), 32'({3'b000, 4'h0, 4'hF}));

    // Random traffic against the reference model, from a fresh reset.
    rst_n = 1'b0;
    m_got = 4'h0;
    m_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 400; c++) begin
      check($sformatf("rand%0d", c), 32'(obs4()), 32'(model_exp()));
      r_rts   = 4'($urandom);
      r_eow   = 4'($urandom) | 4'($urandom);
      r_posit = 16'($urandom);
      r_rtr   = ($urandom_range(0, 3) != 0);
      drive4(r_rts, r_eow, r_posit, r_rtr);
      model_step(r_rts, r_eow, r_posit, r_rtr);
      @(negedge clk);
    end
    drive4(4'h0, 4'h0, 16'h0, 1'b0);

    // Single-lane instance: one beat carries both sow and eow.
    bus1.rts_i = 1'b1; bus1.eow_i = 1'b1; bus1.posit_i = 4'hB; bus1.rtr_i = 1'b1;
    @(negedge clk);
    bus1.rts_i = 1'b0; bus1.eow_i = 1'b0;
    check("nb1_beat", 32'({bus1.rts_o, bus1.sow_o, bus1.eow_o, bus1.posit_o, bus1.rtr_o}),
          32'({3'b111, 4'hB, 1'b0}));
    @(negedge clk);
    check("nb1_idle", 32'({bus1.rts_o, bus1.sow_o, bus1.eow_o, bus1.posit_o, bus1.rtr_o}),
          32'({3'b000, 4'h0, 1'b1}));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
